// File: rtl/spi_target_pkg.sv
// Shared constants and types for the spi_target SPI mode-0 responder.
package spi_target_pkg;

    localparam logic [7:0]  IDLE_BYTE_DEF  = 8'hFF;
    localparam int unsigned SYNC_STAGES    = 2;

    // Mode 0: SCK idles low, sample on the edge leaving idle, shift on the return.
    localparam logic        SCK_IDLE_LEVEL = 1'b0;

    // Bit positions inside the synchronized pin bus {sck, cs_n, mosi}.
    localparam int unsigned PIN_SCK        = 2;
    localparam int unsigned PIN_CSN        = 1;
    localparam int unsigned PIN_MOSI       = 0;
    localparam logic [2:0]  PIN_RST_VAL    = 3'b010;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
        return {cur[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_target_rxfifo.sv
// Synchronous FIFO for received bytes; used by spi_target only with SPI_TARGET_RXFIFO_EN.
module spi_target_rxfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled in the fclk domain.
// Optional rx FIFO (FIFO_DEPTH entries) when SPI_TARGET_RXFIFO_EN is defined.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0]  IDLE_BYTE  = IDLE_BYTE_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic       overrun,
    output logic       sel_start,
    output logic       sel_end
);

    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] pins_s;
    logic [1:0] hist_q;
    logic       sck_lead_s;
    logic       sck_trail_s;
    logic       cs_fall_s;
    logic       cs_rise_s;
    logic       mosi_s;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_empty_q, tx_empty_d;
    logic       reload_q, reload_d;
    logic       byte_done_q, byte_done_d;
    logic       sel_start_q, sel_start_d;
    logic       sel_end_q, sel_end_d;
    logic       miso_q, miso_d;
    logic       overrun_q, overrun_d;
    logic       take_tx_s;

    // Pin synchronizers plus history for sck and cs_n.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= PIN_RST_VAL;
            end
            hist_q <= {PIN_RST_VAL[PIN_SCK], PIN_RST_VAL[PIN_CSN]};
        end else begin
            sync_q[0] <= {sck, cs_n, mosi};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= {sync_q[SYNC_STAGES-1][PIN_SCK], sync_q[SYNC_STAGES-1][PIN_CSN]};
        end
    end

    assign pins_s      = sync_q[SYNC_STAGES-1];
    assign mosi_s      = pins_s[PIN_MOSI];
    assign sck_lead_s  = (pins_s[PIN_SCK] != hist_q[1]) && (pins_s[PIN_SCK] != SCK_IDLE_LEVEL);
    assign sck_trail_s = (pins_s[PIN_SCK] != hist_q[1]) && (pins_s[PIN_SCK] == SCK_IDLE_LEVEL);
    assign cs_fall_s   = hist_q[0] & ~pins_s[PIN_CSN];
    assign cs_rise_s   = ~hist_q[0] & pins_s[PIN_CSN];

    // Transfer FSM, shift registers and tx holding register.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_empty_d  = tx_empty_q;
        reload_d    = reload_q;
        byte_done_d = 1'b0;
        sel_start_d = 1'b0;
        sel_end_d   = 1'b0;
        take_tx_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = 3'd0;
                    reload_d    = 1'b0;
                    sel_start_d = 1'b1;
                    take_tx_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // Deselect outranks any SCK edge seen in the same cycle.
                if (cs_rise_s) begin
                    state_d    = ST_IDLE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                    reload_d   = 1'b0;
                    sel_end_d  = 1'b1;
                end else if (sck_lead_s) begin
                    rx_shift_d = shift_in(rx_shift_q, mosi_s);
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_d = 1'b1;
                        reload_d    = 1'b1;
                    end else begin
                        reload_d = 1'b0;
                    end
                end else if (sck_trail_s) begin
                    if (reload_q) begin
                        take_tx_s = 1'b1;
                        reload_d  = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_tx_s) begin
            tx_shift_d = tx_empty_q ? IDLE_BYTE : tx_buf_q;
        end else begin
            tx_shift_d = tx_shift_d;
        end

        // Core writes only into a free buffer; the shifter frees only a full one.
        if (tx_empty_q) begin
            if (tx_load) begin
                tx_buf_d   = tx_data;
                tx_empty_d = 1'b0;
            end else begin
                tx_empty_d = 1'b1;
            end
        end else begin
            if (take_tx_s) begin
                tx_empty_d = 1'b1;
            end else begin
                tx_empty_d = 1'b0;
            end
        end

        miso_d = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b1;
    end

    // Core state registers.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            tx_buf_q    <= 8'h00;
            tx_empty_q  <= 1'b1;
            reload_q    <= 1'b0;
            byte_done_q <= 1'b0;
            sel_start_q <= 1'b0;
            sel_end_q   <= 1'b0;
            miso_q      <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            reload_q    <= reload_d;
            byte_done_q <= byte_done_d;
            sel_start_q <= sel_start_d;
            sel_end_q   <= sel_end_d;
            miso_q      <= miso_d;
            overrun_q   <= overrun_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = (state_q == ST_ACTIVE);
    assign tx_empty  = tx_empty_q;
    assign sel_start = sel_start_q;
    assign sel_end   = sel_end_q;
    assign overrun   = overrun_q;

`ifdef SPI_TARGET_RXFIFO_EN
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic                        fifo_pop_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused_s;

    assign fifo_pop_s = rx_ready & ~fifo_empty_s;

    spi_target_rxfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rxfifo (
        .clk_i   (fclk),
        .rst_i   (rst),
        .push_i  (byte_done_q),
        .pop_i   (fifo_pop_s),
        .din_i   (rx_shift_q),
        .dout_o  (rx_data),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_unused_s)
    );

    assign rx_valid = ~fifo_empty_s;

    // A byte is lost only when the FIFO is full and not draining this cycle.
    always_comb begin
        overrun_d = byte_done_q & fifo_full_s & ~fifo_pop_s;
    end
`else
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       unused_fifo_depth_s;

    assign unused_fifo_depth_s = (FIFO_DEPTH != 32'd0);

    // Single holding register; a same-cycle handshake frees it for the new byte.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (byte_done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`endif

endmodule
